s2p_lane_ctrl: RTL and testbench

- Sequencing and framing controller for the 4-lane serial-to-parallel front end.
- Drives the shared ENB/MODO/DIR controls of the four per-lane shift registers.
- Hunts for word alignment by comparing lane 0's parallel register against a sync word, confirms it over several frames, then tracks it.
- Issues a one-cycle capture enable (CAPT) to the per-lane capture flip-flops. CAPT replaces the free-running divide-by-8 clock and aligns capture to word boundaries.

---
 rtl/s2p_lane_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_s2p_lane_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s2p_lane_ctrl.sv
// s2p_lane_ctrl: sequencing and framing controller for the 4-lane serial-to-parallel
// front end. Drives the shared shift-register controls, hunts for word alignment on
// lane 0, confirms it over several frames, then tracks it. It issues a one-cycle
// capture enable on each word boundary while locked.
//
// Ports:
//   CLK       shift-register bit clock
//   reset     asynchronous active-low reset
//   start     level; leaves IDLE and begins hunting
//   stop      level; forces IDLE from any state (highest priority)
//   cfg_we    config write strobe, honoured in IDLE only
//   cfg_modo  shift-register mode to latch
//   cfg_dir   shift direction to latch
//   P0        lane 0 shift-register parallel output
//   ENB       shift-register / capture enable
//   MODO      registered shift-register mode
//   DIR       registered shift direction
//   CAPT      capture-enable pulse, once per word while locked
//   lock      high while locked
//   sync_err  one-cycle pulse per sync miss while locked
//   word_idx  current word index within the frame
module s2p_lane_ctrl #(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] SYNC     = 8'hBC,
  parameter int unsigned      FRAME    = 16,
  parameter int unsigned      LOCK_CNT = 3,
  parameter int unsigned      LOSS_CNT = 4
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     cfg_we,
  input  logic [1:0]               cfg_modo,
  input  logic                     cfg_dir,
  input  logic [WIDTH-1:0]         P0,
  output logic                     ENB,
  output logic [1:0]               MODO,
  output logic                     DIR,
  output logic                     CAPT,
  output logic                     lock,
  output logic                     sync_err,
  output logic [$clog2(FRAME)-1:0] word_idx
);

  localparam int unsigned BcW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned WiW   = $clog2(FRAME);
  localparam int unsigned HitW  = $clog2(LOCK_CNT + 1);
  localparam int unsigned MissW = $clog2(LOSS_CNT + 1);

  localparam logic [BcW-1:0]   BitLast  = BcW'(WIDTH - 1);
  localparam logic [WiW-1:0]   WordLast = WiW'(FRAME - 1);
  localparam logic [HitW-1:0]  HitLast  = HitW'(LOCK_CNT - 1);
  localparam logic [MissW-1:0] MissLast = MissW'(LOSS_CNT - 1);

  typedef enum logic [1:0] {StIdle, StHunt, StConfirm, StLocked} state_e;

  state_e           state_q, state_d;
  logic [BcW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WiW-1:0]   word_idx_q, word_idx_d;
  logic [HitW-1:0]  hit_q, hit_d;
  logic [MissW-1:0] miss_q, miss_d;
  logic [1:0]       modo_q, modo_d;
  logic             dir_q, dir_d;
  logic             sync_err_d;
  logic             enb_q, capt_q, lock_q, sync_err_q;

  logic             boundary;
  logic             sync_hit;
  logic             frame_start;
  logic [BcW-1:0]   bit_next;
  logic [WiW-1:0]   word_next;

  assign boundary    = (bit_cnt_q == BitLast);
  assign sync_hit    = (P0 == SYNC);
  assign frame_start = boundary && (word_idx_q == '0);
  assign bit_next    = boundary ? '0 : bit_cnt_q + BcW'(1);
  assign word_next   = (word_idx_q == WordLast) ? '0 : word_idx_q + WiW'(1);

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    word_idx_d = word_idx_q;
    hit_d      = hit_q;
    miss_d     = miss_q;
    modo_d     = modo_q;
    dir_d      = dir_q;
    sync_err_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cfg_we) begin
          modo_d = cfg_modo;
          dir_d  = cfg_dir;
        end
        if (start) begin
          state_d = StHunt;
        end
      end

      StHunt: begin
        // P0 just completed the sync word; the next bit starts word 1.
        if (sync_hit) begin
          state_d    = (LOCK_CNT <= 1) ? StLocked : StConfirm;
          bit_cnt_d  = '0;
          word_idx_d = WiW'(1);
          hit_d      = HitW'(1);
        end
      end

      StConfirm: begin
        bit_cnt_d = bit_next;
        if (boundary) begin
          word_idx_d = word_next;
        end
        if (frame_start) begin
          if (sync_hit) begin
            if (hit_q >= HitLast) begin
              state_d = StLocked;
              hit_d   = HitW'(LOCK_CNT);
            end else begin
              hit_d = hit_q + HitW'(1);
            end
          end else begin
            state_d    = StHunt;
            bit_cnt_d  = '0;
            word_idx_d = '0;
            hit_d      = '0;
          end
        end
      end

      StLocked: begin
        bit_cnt_d = bit_next;
        if (boundary) begin
          word_idx_d = word_next;
        end
        if (frame_start) begin
          if (sync_hit) begin
            miss_d = '0;
          end else begin
            sync_err_d = 1'b1;
            if (miss_q >= MissLast) begin
              state_d    = StHunt;
              bit_cnt_d  = '0;
              word_idx_d = '0;
              hit_d      = '0;
              miss_d     = '0;
            end else begin
              miss_d = miss_q + MissW'(1);
            end
          end
        end
      end
    endcase

    // stop overrides every transition; config latching in IDLE is unaffected.
    if (stop) begin
      state_d    = StIdle;
      bit_cnt_d  = '0;
      word_idx_d = '0;
      hit_d      = '0;
      miss_d     = '0;
      sync_err_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      word_idx_q <= '0;
      hit_q      <= '0;
      miss_q     <= '0;
      modo_q     <= 2'b00;
      dir_q      <= 1'b0;
      enb_q      <= 1'b0;
      capt_q     <= 1'b0;
      lock_q     <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      word_idx_q <= word_idx_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      modo_q     <= modo_d;
      dir_q      <= dir_d;
      // Outputs are registered from the next state so they match a state decode.
      enb_q      <= (state_d != StIdle);
      lock_q     <= (state_d == StLocked);
      capt_q     <= (state_d == StLocked) && (bit_cnt_d == BitLast);
      sync_err_q <= sync_err_d;
    end
  end

  assign ENB      = enb_q;
  assign MODO     = modo_q;
  assign DIR      = dir_q;
  assign CAPT     = capt_q;
  assign lock     = lock_q;
  assign sync_err = sync_err_q;
  assign word_idx = word_idx_q;

endmodule

// File: tb/tb_s2p_lane_ctrl.sv
// Directed bench for s2p_lane_ctrl with a 4-lane shift-register and capture-flop model.
// Stream layout: 3 lead-in bits, then frames of 128 bits (sync word + 15 data words),
// MSB first. Bit b of the stream is shifted in on the b+1-th enabled clock edge.
module tb_s2p_lane_ctrl;

  logic       CLK = 1'b0;
  logic       reset;
  logic       start;
  logic       stop;
  logic       cfg_we;
  logic [1:0] cfg_modo;
  logic       cfg_dir;
  logic [7:0] P0;
  logic       ENB;
  logic [1:0] MODO;
  logic       DIR;
  logic       CAPT;
  logic       lock;
  logic       sync_err;
  logic [3:0] word_idx;

  int total = 0;
  int bad   = 0;

  logic [7:0] sync_of_frame [32];
  logic [7:0] sr  [4] = '{default: 8'h00};
  logic [7:0] cap [4] = '{default: 8'h00};
  int         ptr = 0;

  always #5 CLK = ~CLK;

  s2p_lane_ctrl #(
    .WIDTH   (8),
    .SYNC    (8'hBC),
    .FRAME   (16),
    .LOCK_CNT(3),
    .LOSS_CNT(4)
  ) dut (
    .CLK     (CLK),
    .reset   (reset),
    .start   (start),
    .stop    (stop),
    .cfg_we  (cfg_we),
    .cfg_modo(cfg_modo),
    .cfg_dir (cfg_dir),
    .P0      (P0),
    .ENB     (ENB),
    .MODO    (MODO),
    .DIR     (DIR),
    .CAPT    (CAPT),
    .lock    (lock),
    .sync_err(sync_err),
    .word_idx(word_idx)
  );

  assign P0 = sr[0];

  function automatic logic [7:0] word_of(input int l, input int f, input int w);
    if (w == 0) return (f < 32) ? sync_of_frame[f] : 8'hBC;
    if (l == 0) return 8'(w);
    return 8'(w * 29 + l * 71) ^ 8'h5A;
  endfunction

  function automatic logic stream_bit(input int l, input int b);
    int o;
    logic [7:0] v;
    if (b < 3) return (b == 1);
    o = b - 3;
    v = word_of(l, o / 128, (o % 128) / 8);
    return v[7 - (o % 8)];
  endfunction

  always @(posedge CLK) begin
    if (ENB === 1'b1) begin
      for (int l = 0; l < 4; l++) sr[l] <= {sr[l][6:0], stream_bit(l, ptr)};
      ptr <= ptr + 1;
    end
    if (CAPT === 1'b1) begin
      for (int l = 0; l < 4; l++) cap[l] <= sr[l];
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ptr(input int k);
    int guard = 0;
    while (ptr < k && guard < 3000) begin
      tick();
      guard++;
    end
    check("wait_ptr", ptr, k);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_enb"}, ENB, 0);
    check({tag, "_modo"}, MODO, 0);
    check({tag, "_dir"}, DIR, 0);
    check({tag, "_capt"}, CAPT, 0);
    check({tag, "_lock"}, lock, 0);
    check({tag, "_serr"}, sync_err, 0);
    check({tag, "_widx"}, word_idx, 0);
  endtask

  initial begin
    int errs;
    int drop;
    int capt_seen;
    int w;

    for (int f = 0; f < 32; f++) sync_of_frame[f] = 8'hBC;
    sync_of_frame[4]  = 8'hBD;
    for (int f = 6; f <= 9; f++) sync_of_frame[f] = 8'hBD;
    sync_of_frame[11] = 8'h00;

    reset = 1'b0; start = 1'b0; stop = 1'b0;
    cfg_we = 1'b0; cfg_modo = 2'b00; cfg_dir = 1'b0;

    // Inputs active while in reset must have no effect.
    cfg_we = 1'b1; cfg_modo = 2'b10; cfg_dir = 1'b1; start = 1'b1;
    repeat (2) tick();
    check_all_zero("rst");
    cfg_we = 1'b0; start = 1'b0;
    reset = 1'b1;
    tick();
    check("idle_enb", ENB, 0);

    // Config in IDLE, then start.
    cfg_we = 1'b1; cfg_modo = 2'b10; cfg_dir = 1'b1;
    tick();
    cfg_we = 1'b0;
    check("cfg_modo", MODO, 2'b10);
    check("cfg_dir", DIR, 1);
    check("cfg_enb", ENB, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_enb", ENB, 1);
    check("start_lock", lock, 0);

    // Sync complete after 11 shifts; matched on the 12th edge.
    wait_ptr(11);
    check("hunt_widx", word_idx, 0);
    tick();
    check("confirm_widx", word_idx, 1);
    check("confirm_lock", lock, 0);

    // Third sync match 256 clocks later.
    wait_ptr(267);
    check("prelock", lock, 0);
    check("prelock_capt", CAPT, 0);
    tick();
    check("lock", lock, 1);
    check("lock_widx", word_idx, 1);

    // One frame of captures: every 8 clocks, word_idx 1..15,0, data on all lanes.
    for (int t = 1; t <= 128; t++) begin
      tick();
      check("capt_pat", CAPT, (t % 8 == 7) ? 1 : 0);
      if (t % 8 == 7) check("capt_widx", word_idx, ((t / 8) + 1) % 16);
      if (t % 8 == 0) begin
        w = (t / 8) % 16;
        for (int l = 0; l < 4; l++) check("cap_data", cap[l], word_of(l, 3, w));
      end
    end
    check("good_serr", sync_err, 0);

    // Single bad sync (frame 4), then good (frame 5): lock held.
    wait_ptr(523);
    check("serr_pre", sync_err, 0);
    tick();
    check("serr_one", sync_err, 1);
    check("serr_lock", lock, 1);
    tick();
    check("serr_pulse", sync_err, 0);
    wait_ptr(652);
    check("single_keep", lock, 1);
    check("single_serr", sync_err, 0);

    // Four consecutive bad syncs (frames 6..9): drop at the 4th miss.
    errs = 0; drop = 0;
    while (ptr < 1164 && errs < 100) begin
      tick();
      if (sync_err) errs++;
      if (!lock && drop == 0) drop = ptr;
    end
    check("loss_errs", errs, 4);
    check("loss_edge", drop, 1164);
    check("loss_enb", ENB, 1);

    // Hunt matches frame 10, frame 11 sync is 00 -> back to hunting, no captures.
    capt_seen = 0;
    while (ptr < 1291) begin
      tick();
      if (CAPT) capt_seen++;
      if (ptr > 2000) break;
    end
    check("rehunt_widx", word_idx, 0);
    tick();
    check("rehunt_confirm", word_idx, 1);
    while (ptr < 1420) begin
      tick();
      if (CAPT) capt_seen++;
      if (ptr > 2000) break;
    end
    check("badconf_capt", capt_seen, 0);
    check("badconf_lock", lock, 0);
    wait_ptr(1540);
    check("badconf_hold", (word_idx <= 4'd1), 1);
    wait_ptr(1803);
    check("relock_pre", lock, 0);
    tick();
    check("relock", lock, 1);

    // cfg_we ignored outside IDLE.
    cfg_we = 1'b1; cfg_modo = 2'b01; cfg_dir = 1'b0;
    tick();
    cfg_we = 1'b0;
    check("lock_cfg_modo", MODO, 2'b10);
    check("lock_cfg_dir", DIR, 1);

    // Asynchronous reset mid-word (bit_cnt = 4).
    wait_ptr(1808);
    check("prereset_widx", word_idx, 1);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async_rst");
    tick();
    reset = 1'b1;
    tick();
    check("post_rst_enb", ENB, 0);

    // start and stop together stay in IDLE.
    start = 1'b1; stop = 1'b1;
    tick();
    stop = 1'b0;
    check("startstop_enb", ENB, 0);
    tick();
    start = 1'b0;
    check("restart_enb", ENB, 1);

    // Re-acquire: sync 15 matched at 1932, locked 256 clocks later.
    wait_ptr(2187);
    check("reacq_pre", lock, 0);
    tick();
    check("reacq", lock, 1);

    // stop in LOCKED.
    repeat (3) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_enb", ENB, 0);
    check("stop_lock", lock, 0);
    check("stop_capt", CAPT, 0);
    check("stop_widx", word_idx, 0);
    tick();
    check("stop_hold", ENB, 0);

    // cfg_we and start in the same IDLE cycle both take effect.
    cfg_we = 1'b1; cfg_modo = 2'b11; cfg_dir = 1'b0; start = 1'b1;
    tick();
    cfg_we = 1'b0; start = 1'b0;
    check("both_enb", ENB, 1);
    check("both_modo", MODO, 2'b11);
    check("both_dir", DIR, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
